// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// states, byte/halfword/word access, alignment and range fault detection, and
// a byte-laned word RAM. One request is accepted in IDLE, the block stalls in
// WAIT, then presents a one-cycle response in RESP.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [32:0]      ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_START  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             enter_resp;

  // Latched request, captured on acceptance and held through WAIT
  logic        wr_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  // Response-side registers; these hold until the next response is issued
  logic        resp_err_q;
  logic        rd_ok_q;
  logic [1:0]  rd_size_q;
  logic [1:0]  rd_lane_q;
  logic [31:0] rd_word;

  // The operation being completed: in IDLE (zero wait states) the live inputs,
  // otherwise the copy latched at acceptance.
  logic             in_idle;
  logic             op_write;
  logic [31:0]      op_addr;
  logic [1:0]       op_size;
  logic [31:0]      op_wdata;
  logic             op_err;
  logic             do_store;
  logic             do_load;
  logic [IDX_W-1:0] word_idx;

  assign in_idle  = (state_q == ST_IDLE);
  assign op_write = in_idle ? req_write : wr_q;
  assign op_addr  = in_idle ? req_addr  : addr_q;
  assign op_size  = in_idle ? req_size  : size_q;
  assign op_wdata = in_idle ? req_wdata : wdata_q;

  // Fault if the size is illegal, the access is misaligned, or the address
  // lies beyond the RAM; the compare is done on 33 bits so nothing wraps.
  assign op_err = (op_size == SZ_ILL)
               || ((op_size == SZ_HALF) && op_addr[0])
               || ((op_size == SZ_WORD) && (op_addr[1:0] != 2'b00))
               || ({1'b0, op_addr} >= ADDR_LIMIT);

  assign do_store = enter_resp &&  op_write && !op_err;
  assign do_load  = enter_resp && !op_write && !op_err;
  assign word_idx = op_addr[IDX_W+1:2];

  assign req_ready  = in_idle;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_err_q;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_START;
          end else begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture the request on acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      size_q  <= req_size;
      wdata_q <= req_wdata;
    end
  end

  // Record how the response data is to be formed, on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_err_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      rd_size_q  <= SZ_WORD;
      rd_lane_q  <= 2'b00;
    end else if (enter_resp) begin
      resp_err_q <= op_err;
      rd_ok_q    <= !op_write && !op_err;
      rd_size_q  <= op_size;
      rd_lane_q  <= op_addr[1:0];
    end
  end

  // Four byte-wide RAM lanes give per-byte write enables with a plain
  // registered read on each lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] ram_q [DEPTH_WORDS];
    logic [7:0] rd_byte_q;
    logic       lane_we;
    logic [7:0] lane_wd;

    assign lane_we = (op_size == SZ_WORD)
                  || ((op_size == SZ_HALF) && (op_addr[1] == 1'(gi / 2)))
                  || ((op_size == SZ_BYTE) && (op_addr[1:0] == 2'(gi)));
    assign lane_wd = (op_size == SZ_WORD) ? op_wdata[8*gi +: 8]
                   : (op_size == SZ_HALF) ? op_wdata[8*(gi % 2) +: 8]
                   : op_wdata[7:0];

    // Commit store bytes and read load bytes on the edge entering RESP
    always_ff @(posedge clk) begin
      if (do_store && lane_we) begin
        ram_q[word_idx] <= lane_wd;
      end
      if (do_load) begin
        rd_byte_q <= ram_q[word_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_q;
  end

  // Select and zero-extend the addressed subword; stores and faults read 0
  always_comb begin
    resp_rdata = '0;
    if (rd_ok_q) begin
      case (rd_size_q)
        SZ_WORD: resp_rdata = rd_word;
        SZ_HALF: resp_rdata = rd_lane_q[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
        SZ_BYTE: begin
          case (rd_lane_q)
            2'd0:    resp_rdata = {24'h0, rd_word[7:0]};
            2'd1:    resp_rdata = {24'h0, rd_word[15:8]};
            2'd2:    resp_rdata = {24'h0, rd_word[23:16]};
            default: resp_rdata = {24'h0, rd_word[31:24]};
          endcase
        end
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's load/store path. It accepts one request at a time over a valid/ready handshake and supports word, halfword and byte sizes.
- It stalls for a configurable number of wait states, then returns a single-cycle response carrying read data or an error flag.
- It owns a word-organised RAM and lets the multicycle control unit be exercised against a memory with real latency and alignment faults.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the internal RAM; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
- req_wdata  input  32  store data; the subword is taken from the low bits.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data, zero-extended; 0 for stores and errors.
- resp_err  output  1  request faulted; qualified by resp_valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low. While reset is low: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance occurs on a clock edge where req_valid&&req_ready.
  - On acceptance, latch write/addr/size/wdata and compute the error flag.
  - If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1; otherwise go to RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When counter==0, go to RESP.
  - Input changes after acceptance are ignored.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; return to IDLE.
  - There is no response backpressure.
- Latency: resp_valid is high in the cycle starting WAIT_CYCLES+1 edges after the acceptance edge. Minimum issue interval is WAIT_CYCLES+2 cycles.
- Errors (resp_err=1), by priority (any one faults):
  - size==11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr >= 4*DEPTH_WORDS.
- An errored store does not modify the RAM. An errored load returns resp_rdata=0. Error responses obey the same latency as good ones.
- Addressing: word index = addr[31:2]. Byte lane = addr[1:0], little-endian: lane 0 = bits 7:0.
  - Halfword at addr[1]=0 uses bits 15:0; at addr[1]=1 it uses bits 31:16.
- Loads:
  - The RAM word is read at the WAIT->RESP (or IDLE->RESP) transition.
  - The selected subword is zero-extended into resp_rdata.
  - resp_rdata holds its value until the next response, and is 0 for store responses.
- Stores:
  - The RAM is written on the edge entering RESP; only the addressed byte lanes change.
  - Byte store writes req_wdata[7:0]; halfword store writes req_wdata[15:0].
  - A load issued after a store's resp_valid observes the new data.
- Reset mid-operation: a store not yet in RESP is not committed, and no response is issued. After reset is released, the block is in IDLE with req_ready=1.
- req_valid while req_ready=0 is not accepted and carries no side effect. The requester must hold req_valid until acceptance.
- Address arithmetic is unsigned 32-bit; there is no wrap-around. Out-of-range addresses always fault.

Test Plan:
1. Word write 0xDEADBEEF at addr 0x10, then word read 0x10 (WAIT_CYCLES=2): resp_valid 3 cycles after each acceptance, read resp_rdata=0xDEADBEEF, resp_err=0, req_ready low for 3 cycles after each acceptance.
2. After test 1, byte store 0x55 at 0x12, then halfword read 0x12 -> 0x0000DE55; byte read 0x13 -> 0x000000DE; word read 0x10 -> 0xDE55BEEF.
3. Faults:
   - Word read 0x11, halfword store 0x21, size=11 at 0x0, and word read at 4*DEPTH_WORDS (0x100): each gives resp_err=1, resp_rdata=0.
   - A following word read 0x20 is unchanged from its prior value.
4. Back-to-back: hold req_valid high with two queued loads -> second acceptance occurs exactly WAIT_CYCLES+2 cycles after the first; exactly one resp_valid pulse per request.
5. Assert reset low during WAIT of a word store 0x12345678 to 0x30 (previously 0xAAAAAAAA) -> outputs return to reset values immediately; no resp_valid; after release, read 0x30 returns 0xAAAAAAAA.
6. WAIT_CYCLES=0 build: word write then read at 0x4 -> resp_valid one cycle after each acceptance, data matches.
